mem_arb_rr_n: RTL and testbench

- Parametrised N-port arbiter that multiplexes N memory/cache masters onto one Wishbone-side memory request channel.
- Successor of the fixed 2-port data-cache arbiter. Adds:
  - configurable port count and widths;
  - a round-robin or fixed-priority mode;
  - a per-port lock for back-to-back atomic sequences;
  - a grant/owner status output.
- Sits between the data/instruction cache masters and the memory bus front-end.

---
 rtl/mem_arb_rr_n_pkg.sv | 14 +
 rtl/mem_arb_rr_n_if.sv | 41 ++++
 rtl/mem_arb_rr_n_arb_rr_pick.sv | 27 ++
 rtl/mem_arb_rr_n.sv | 73 +++++++
 tb/tb_mem_arb_rr_n.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_rr_n_pkg.sv
// mem_arb_rr_n_pkg: shared constants, state type and slot helper for the N-port memory arbiter.
//   WB_ADDR_W / RW   default address and data widths of the memory bus
//   ARB_RR/ARB_FIXED arbitration modes (round-robin / lowest index wins)
//   rr_slot          k-th port visited by a search starting after `last`
package mem_arb_rr_n_pkg;
  localparam int WB_ADDR_W = 24;
  localparam int RW = 16;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;
  typedef enum logic {IDLE, ACTIVE} arb_state_e;
  function automatic int rr_slot(input int last, input int k, input int n, input bit fixed);
    return fixed ? k : (last + 1 + k) % n;
  endfunction
endpackage

// File: rtl/mem_arb_rr_n_if.sv
// mem_arb_rr_n_if: memory-channel and per-port request bundle around the arbiter.
//   mem_*  single memory front-end channel (arbiter drives request side)
//   p_*    per-port vectors, port i at slice i of each field
//   master modport is the arbiter view, slave modport is the environment view
interface mem_arb_rr_n_if import mem_arb_rr_n_pkg::*; #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = RW
) ();
  logic                       mem_req;
  logic                       mem_we;
  logic                       mem_ack;
  logic                       mem_exception;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_o_data;
  logic [DATA_W-1:0]          mem_i_data;
  logic [1:0]                 mem_sel;
  logic                       mem_cache_enable;
  logic [N_PORTS-1:0]         p_req;
  logic [N_PORTS-1:0]         p_we;
  logic [N_PORTS*ADDR_W-1:0]  p_addr;
  logic [N_PORTS*DATA_W-1:0]  p_o_data;
  logic [N_PORTS*2-1:0]       p_sel;
  logic [N_PORTS-1:0]         p_cache_enable;
  logic [N_PORTS-1:0]         p_lock;
  logic [N_PORTS-1:0]         p_ack;
  logic [N_PORTS-1:0]         p_exception;
  logic [N_PORTS*DATA_W-1:0]  p_i_data;
  modport master (
    output mem_req, mem_we, mem_addr, mem_o_data, mem_sel, mem_cache_enable,
    output p_ack, p_exception, p_i_data,
    input  mem_ack, mem_exception, mem_i_data,
    input  p_req, p_we, p_addr, p_o_data, p_sel, p_cache_enable, p_lock
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_o_data, mem_sel, mem_cache_enable,
    input  p_ack, p_exception, p_i_data,
    output mem_ack, mem_exception, mem_i_data,
    output p_req, p_we, p_addr, p_o_data, p_sel, p_cache_enable, p_lock
  );
endinterface

// File: rtl/mem_arb_rr_n_arb_rr_pick.sv
// arb_rr_pick: combinational winner search over a want vector, round-robin or fixed priority.
//   want_i  requesting ports       last_i  previous owner (round-robin start point)
//   fixed_i 1 = lowest index wins  idx_o   winner index, valid_o any port wanting
module arb_rr_pick import mem_arb_rr_n_pkg::*; #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  want_i,
  input  logic [IW-1:0] last_i,
  input  logic          fixed_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [IW-1:0] slot [N];
  for (genvar k = 0; k < N; k++) begin : g_slot
    assign slot[k] = IW'(rr_slot(int'(last_i), k, N, fixed_i));
  end
  always_comb begin
    idx_o = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++)
      if (!valid_o && want_i[slot[k]]) begin
        idx_o = slot[k];
        valid_o = 1'b1;
      end
  end
endmodule

// File: rtl/mem_arb_rr_n.sv
// mem_arb_rr_n: N-port arbiter multiplexing cache masters onto one memory request channel.
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus           mem_arb_rr_n_if master view (memory channel + per-port vectors)
//   grant_idx     current owner (combinational winner in the start cycle)
//   busy          transfer in flight
module mem_arb_rr_n import mem_arb_rr_n_pkg::*; #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = RW,
  parameter int MODE = ARB_RR,
  parameter int IW = $clog2(N_PORTS)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mem_arb_rr_n_if.master bus,
  output logic [IW-1:0]  grant_idx,
  output logic           busy
);
  localparam int PW = N_PORTS * DATA_W;
  arb_state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, lock_port_q, lock_port_d, win, sel_idx;
  logic [N_PORTS-1:0] pending_q, pending_d, want, eligible, owner_mask, win_mask;
  logic lock_held_q, lock_held_d, win_valid, active, start, term;
  assign want = bus.p_req | pending_q;
  // a held lock narrows eligibility to the lock owner; other pending bits survive
  assign eligible = lock_held_q ? want & (N_PORTS'(1) << lock_port_q) : want;
  arb_rr_pick #(.N(N_PORTS), .IW(IW)) u_pick (
    .want_i  (eligible),
    .last_i  (owner_q),
    .fixed_i (MODE == ARB_FIXED),
    .idx_o   (win),
    .valid_o (win_valid)
  );
  assign active = state_q == ACTIVE;
  assign start = !active && win_valid && !i_rst;
  assign term = active && (bus.mem_ack || bus.mem_exception);
  assign sel_idx = start ? win : owner_q;
  assign owner_mask = N_PORTS'(1) << owner_q;
  assign win_mask = N_PORTS'(1) << win;
  always_comb begin
    state_d = start ? ACTIVE : term ? IDLE : state_q;
    owner_d = start ? win : owner_q;
    // owner strobes while active are protocol violations and are dropped
    pending_d = (pending_q | (bus.p_req & ~(active ? owner_mask : '0))) & ~(start ? win_mask : '0);
    lock_held_d = term ? bus.mem_ack && !bus.mem_exception && bus.p_lock[owner_q] : lock_held_q;
    lock_port_d = term ? owner_q : lock_port_q;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= IW'(N_PORTS - 1);
      pending_q <= '0;
      lock_held_q <= 1'b0;
      lock_port_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pending_q <= pending_d;
      lock_held_q <= lock_held_d;
      lock_port_q <= lock_port_d;
    end
  assign bus.mem_req = start;
  assign bus.mem_we = bus.p_we[sel_idx];
  assign bus.mem_addr = bus.p_addr[sel_idx*ADDR_W +: ADDR_W];
  assign bus.mem_o_data = bus.p_o_data[sel_idx*DATA_W +: DATA_W];
  assign bus.mem_sel = bus.p_sel[sel_idx*2 +: 2];
  assign bus.mem_cache_enable = bus.p_cache_enable[sel_idx];
  assign bus.p_ack = {N_PORTS{active && bus.mem_ack}} & owner_mask;
  assign bus.p_exception = {N_PORTS{active && bus.mem_exception}} & owner_mask;
  assign bus.p_i_data = PW'(bus.mem_i_data) << (sel_idx * DATA_W);
  assign grant_idx = sel_idx;
  assign busy = active;
endmodule

// File: tb/tb_mem_arb_rr_n.sv
// tb_mem_arb_rr_n: scoreboard bench for mem_arb_rr_n in round-robin and fixed-priority modes.
module tb_mem_arb_rr_n;
  import mem_arb_rr_n_pkg::*;
  localparam int N = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  typedef struct {
    int port;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic we;
    logic [1:0] sel;
    logic ce;
  } exp_t;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;
  logic [N-1:0] p_req = '0, p_we = 4'b0101, p_ce = 4'b0011, p_lock = '0;
  logic [AW-1:0] pa [N];
  logic [DW-1:0] pd [N];
  logic [1:0] ps [N];
  logic [N*AW-1:0] p_addr_v;
  logic [N*DW-1:0] p_data_v;
  logic [N*2-1:0] p_sel_v;
  logic mem_ack, mem_exception;
  logic [DW-1:0] mem_i_data;
  always_comb begin
    p_addr_v = '0;
    p_data_v = '0;
    p_sel_v = '0;
    for (int i = 0; i < N; i++) begin
      p_addr_v[i*AW +: AW] = pa[i];
      p_data_v[i*DW +: DW] = pd[i];
      p_sel_v[i*2 +: 2] = ps[i];
    end
  end
  mem_arb_rr_n_if #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) b0 ();
  mem_arb_rr_n_if #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) b1 ();
  assign b0.p_req = p_req;          assign b1.p_req = p_req;
  assign b0.p_we = p_we;            assign b1.p_we = p_we;
  assign b0.p_addr = p_addr_v;      assign b1.p_addr = p_addr_v;
  assign b0.p_o_data = p_data_v;    assign b1.p_o_data = p_data_v;
  assign b0.p_sel = p_sel_v;        assign b1.p_sel = p_sel_v;
  assign b0.p_cache_enable = p_ce;  assign b1.p_cache_enable = p_ce;
  assign b0.p_lock = p_lock;        assign b1.p_lock = p_lock;
  assign b0.mem_ack = mem_ack;      assign b1.mem_ack = mem_ack;
  assign b0.mem_exception = mem_exception;  assign b1.mem_exception = mem_exception;
  assign b0.mem_i_data = mem_i_data;        assign b1.mem_i_data = mem_i_data;
  logic [1:0] g0, g1;
  logic busy0, busy1;
  mem_arb_rr_n #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MODE(ARB_RR)) u_rr (
    .i_clk(i_clk), .i_rst(i_rst), .bus(b0), .grant_idx(g0), .busy(busy0));
  mem_arb_rr_n #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MODE(ARB_FIXED)) u_fx (
    .i_clk(i_clk), .i_rst(i_rst), .bus(b1), .grant_idx(g1), .busy(busy1));
  logic sel = 1'b0;
  logic s_req, s_we, s_ce, s_busy;
  logic [1:0] s_grant, s_sel;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [N-1:0] s_ack, s_exc;
  logic [N*DW-1:0] s_rdata;
  assign s_req = sel ? b1.mem_req : b0.mem_req;
  assign s_we = sel ? b1.mem_we : b0.mem_we;
  assign s_ce = sel ? b1.mem_cache_enable : b0.mem_cache_enable;
  assign s_busy = sel ? busy1 : busy0;
  assign s_grant = sel ? g1 : g0;
  assign s_sel = sel ? b1.mem_sel : b0.mem_sel;
  assign s_addr = sel ? b1.mem_addr : b0.mem_addr;
  assign s_wdata = sel ? b1.mem_o_data : b0.mem_o_data;
  assign s_ack = sel ? b1.p_ack : b0.p_ack;
  assign s_exc = sel ? b1.p_exception : b0.p_exception;
  assign s_rdata = sel ? b1.p_i_data : b0.p_i_data;
  int checks = 0, failures = 0, req_count = 0;
  int ack_lat = 1;
  logic exc_next = 1'b0, drop_next = 1'b0, resp_busy = 1'b0;
  exp_t exp_q [$];

  // memory model: pops the scoreboard on every mem_req, answers after ack_lat cycles
  initial begin : responder
    exp_t e;
    int lat;
    logic exc, drop;
    logic [DW-1:0] rd;
    logic [N*DW-1:0] exp_rd;
    mem_ack = 1'b0;
    mem_exception = 1'b0;
    mem_i_data = '0;
    forever begin
      @(negedge i_clk);
      if (s_req) begin
        req_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req got grant_idx=%0d addr=%h expected no request", s_grant, s_addr);
        end else begin
          e = exp_q.pop_front();
          if (s_grant !== 2'(e.port) || s_addr !== e.addr || s_wdata !== e.wdata || s_we !== e.we || s_sel !== e.sel || s_ce !== e.ce) begin
            failures++;
            $display("FAIL grant got idx=%0d addr=%h data=%h we=%b sel=%b ce=%b expected idx=%0d addr=%h data=%h we=%b sel=%b ce=%b",
                     s_grant, s_addr, s_wdata, s_we, s_sel, s_ce, e.port, e.addr, e.wdata, e.we, e.sel, e.ce);
          end
          resp_busy = 1'b1;
          lat = ack_lat;
          exc = exc_next;
          exc_next = 1'b0;
          drop = drop_next;
          drop_next = 1'b0;
          repeat (lat) @(posedge i_clk);
          #1;
          rd = 16'($urandom);
          mem_i_data = rd;
          mem_ack = !exc;
          mem_exception = exc;
          @(negedge i_clk);
          checks++;
          if (drop) begin
            if (s_ack !== '0 || s_exc !== '0 || s_busy !== 1'b0) begin
              failures++;
              $display("FAIL late_ack got p_ack=%b p_exception=%b busy=%b expected 0000 0000 0", s_ack, s_exc, s_busy);
            end
          end else begin
            exp_rd = (N*DW)'(rd) << (e.port * DW);
            if (s_ack !== (exc ? 4'b0 : 4'(1 << e.port)) || s_exc !== (exc ? 4'(1 << e.port) : 4'b0) || s_rdata !== exp_rd) begin
              failures++;
              $display("FAIL routing got p_ack=%b p_exception=%b p_i_data=%h expected p_ack=%b p_exception=%b p_i_data=%h",
                       s_ack, s_exc, s_rdata, exc ? 4'b0 : 4'(1 << e.port), exc ? 4'(1 << e.port) : 4'b0, exp_rd);
            end
          end
          @(posedge i_clk);
          #1;
          mem_ack = 1'b0;
          mem_exception = 1'b0;
          resp_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic push(input int p);
    exp_q.push_back('{p, pa[p], pd[p], p_we[p], ps[p], p_ce[p]});
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    p_req = '0;
    p_lock = '0;
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || resp_busy || s_busy) && n < 60) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || resp_busy || s_busy) begin
      failures++;
      $display("FAIL %s_timeout got %0d grants outstanding busy=%b expected 0 outstanding", name, exp_q.size(), s_busy);
    end
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    p_req = 4'b1111;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (s_req !== 1'b0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_req_busy got mem_req=%b busy=%b expected 0 0", s_req, s_busy);
    end
    checks++;
    if (s_grant !== 2'd3) begin
      failures++;
      $display("FAIL reset_grant got %0d expected 3", s_grant);
    end
    checks++;
    if (s_ack !== '0 || s_exc !== '0) begin
      failures++;
      $display("FAIL reset_ack got p_ack=%b p_exception=%b expected 0000 0000", s_ack, s_exc);
    end
    @(posedge i_clk);
    #1;
    p_req = '0;
    i_rst = 1'b0;
    wait_idle("reset");
  endtask

  task automatic test_rr_order();
    int base;
    sel = 1'b0;
    do_reset();
    ack_lat = 1;
    base = req_count;
    push(0);
    push(2);
    push(3);
    p_req = 4'b1101;
    @(negedge i_clk);
    checks++;
    if (s_req !== 1'b1 || s_grant !== 2'd0) begin
      failures++;
      $display("FAIL rr_zero_latency got mem_req=%b grant=%0d expected 1 0", s_req, s_grant);
    end
    @(posedge i_clk);
    #1;
    p_req = '0;
    wait_idle("rr_order");
    checks++;
    if (req_count - base != 3) begin
      failures++;
      $display("FAIL rr_req_count got %0d expected 3", req_count - base);
    end
  endtask

  task automatic test_pending();
    int n = 0;
    sel = 1'b0;
    do_reset();
    ack_lat = 5;
    push(0);
    push(1);
    p_req = 4'b0001;
    @(posedge i_clk);
    #1;
    p_req = 4'b0010;
    @(posedge i_clk);
    #1;
    p_req = '0;
    do begin
      @(negedge i_clk);
      n++;
    end while (s_ack[0] !== 1'b1 && n < 12);
    checks++;
    if (s_ack[0] !== 1'b1 || s_req !== 1'b0) begin
      failures++;
      $display("FAIL pending_term got p_ack0=%b mem_req=%b expected 1 0", s_ack[0], s_req);
    end
    @(negedge i_clk);
    checks++;
    if (s_req !== 1'b1 || s_grant !== 2'd1 || s_addr !== pa[1]) begin
      failures++;
      $display("FAIL pending_regrant got mem_req=%b grant=%0d addr=%h expected 1 1 %h", s_req, s_grant, s_addr, pa[1]);
    end
    wait_idle("pending");
  endtask

  task automatic test_fixed();
    sel = 1'b1;
    do_reset();
    ack_lat = 1;
    push(1);
    push(1);
    push(3);
    p_req = 4'b1010;
    @(negedge i_clk);
    checks++;
    if (s_req !== 1'b1 || s_grant !== 2'd1) begin
      failures++;
      $display("FAIL fixed_first got mem_req=%b grant=%0d expected 1 1", s_req, s_grant);
    end
    @(posedge i_clk);
    #1;
    p_req = '0;
    @(posedge i_clk);
    #1;
    p_req = 4'b0010;
    @(negedge i_clk);
    checks++;
    if (s_req !== 1'b1 || s_grant !== 2'd1) begin
      failures++;
      $display("FAIL fixed_priority got mem_req=%b grant=%0d expected 1 1", s_req, s_grant);
    end
    @(posedge i_clk);
    #1;
    p_req = '0;
    wait_idle("fixed");
    sel = 1'b0;
  endtask

  task automatic test_lock();
    sel = 1'b0;
    do_reset();
    ack_lat = 2;
    push(2);
    push(2);
    push(0);
    p_lock = 4'b0100;
    p_req = 4'b0100;
    @(posedge i_clk);
    #1;
    p_req = 4'b0001;
    @(posedge i_clk);
    #1;
    p_req = '0;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    checks++;
    if (s_req !== 1'b0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL lock_blocks got mem_req=%b busy=%b expected 0 0", s_req, s_busy);
    end
    @(posedge i_clk);
    #1;
    p_lock = '0;
    p_req = 4'b0100;
    @(negedge i_clk);
    checks++;
    if (s_req !== 1'b1 || s_grant !== 2'd2) begin
      failures++;
      $display("FAIL lock_regrant got mem_req=%b grant=%0d expected 1 2", s_req, s_grant);
    end
    @(posedge i_clk);
    #1;
    p_req = '0;
    wait_idle("lock");
  endtask

  task automatic test_exception();
    sel = 1'b0;
    do_reset();
    ack_lat = 1;
    push(1);
    push(1);
    push(3);
    push(0);
    p_lock = 4'b0010;
    p_req = 4'b0010;
    @(posedge i_clk);
    #1;
    p_req = '0;
    exc_next = 1'b1;
    @(posedge i_clk);
    #1;
    p_req = 4'b0010;
    @(posedge i_clk);
    #1;
    p_req = 4'b1001;
    @(negedge i_clk);
    checks++;
    if (s_exc !== 4'b0010 || s_ack !== 4'b0000 || s_req !== 1'b0) begin
      failures++;
      $display("FAIL exc_route got p_exception=%b p_ack=%b mem_req=%b expected 0010 0000 0", s_exc, s_ack, s_req);
    end
    @(posedge i_clk);
    #1;
    p_req = '0;
    @(negedge i_clk);
    checks++;
    if (s_exc !== 4'b0000 || s_req !== 1'b1 || s_grant !== 2'd3) begin
      failures++;
      $display("FAIL exc_unlock got p_exception=%b mem_req=%b grant=%0d expected 0000 1 3", s_exc, s_req, s_grant);
    end
    wait_idle("exception");
    p_lock = '0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_reset();
    ack_lat = 8;
    drop_next = 1'b1;
    push(0);
    p_req = 4'b0001;
    @(posedge i_clk);
    #1;
    p_req = '0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    checks++;
    if (s_busy !== 1'b0 || s_grant !== 2'd3) begin
      failures++;
      $display("FAIL mid_reset got busy=%b grant=%0d expected 0 3", s_busy, s_grant);
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    wait_idle("mid_reset");
    ack_lat = 1;
    push(0);
    p_req = 4'b0001;
    @(negedge i_clk);
    checks++;
    if (s_req !== 1'b1 || s_grant !== 2'd0 || s_addr !== pa[0]) begin
      failures++;
      $display("FAIL post_reset_grant got mem_req=%b grant=%0d addr=%h expected 1 0 %h", s_req, s_grant, s_addr, pa[0]);
    end
    @(posedge i_clk);
    #1;
    p_req = '0;
    wait_idle("post_reset");
  endtask

  initial begin : main
    for (int i = 0; i < N; i++) begin
      pa[i] = AW'(24'h3C0000 + i * 24'h011111);
      pd[i] = DW'(16'hA000 + i * 16'h0101);
      ps[i] = 2'(i);
    end
    test_reset();
    test_rr_order();
    test_pending();
    test_fixed();
    test_lock();
    test_exception();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
